// File: rtl/branch_predictor_2bit.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational fetch lookup, EX-stage resolution, misprediction and perf counters.
module branch_predictor_2bit #(
   parameter int ENTRIES = 32,
   parameter int IDX_W   = 5
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] if_pc_i,
   output logic        pred_taken_o,
   output logic [31:0] pred_pc_o,
   input  logic        ex_valid_i,
   input  logic [31:0] ex_pc_i,
   input  logic        ex_is_branch_i,
   input  logic        ex_taken_i,
   input  logic [31:0] ex_target_i,
   input  logic        ex_pred_taken_i,
   input  logic [31:0] ex_pred_pc_i,
   output logic        mis_hit_o,
   output logic [31:0] redirect_pc_o,
   output logic [31:0] br_cnt_o,
   output logic [31:0] miss_cnt_o
);

   localparam int TAG_W = 30 - IDX_W;

   logic [ENTRIES-1:0] vld_q;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [31:0]        tgt_q [ENTRIES];
   logic [1:0]         cnt_q [ENTRIES];

   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;

   logic [IDX_W-1:0] e_idx;
   logic [TAG_W-1:0] e_tag;
   logic             e_hit;
   logic             upd;
   logic [1:0]       cnt_nxt;

   assign f_idx = if_pc_i[IDX_W+1:2];
   assign f_tag = if_pc_i[31:IDX_W+2];
   assign e_idx = ex_pc_i[IDX_W+1:2];
   assign e_tag = ex_pc_i[31:IDX_W+2];

   // Reset gating keeps outputs quiet even while the table is being cleared.
   assign f_hit = rst_ni && vld_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign e_hit = vld_q[e_idx] && (tag_q[e_idx] == e_tag);
   assign upd   = rst_ni && ex_valid_i && ex_is_branch_i;

   assign pred_taken_o = f_hit && cnt_q[f_idx][1];
   assign pred_pc_o    = pred_taken_o ? tgt_q[f_idx] : if_pc_i + 32'd4;

   always_comb begin
      mis_hit_o = 1'b0;
      if (rst_ni && ex_valid_i) begin
         if (ex_is_branch_i) begin
            mis_hit_o = (ex_taken_i != ex_pred_taken_i) ||
                        (ex_taken_i && (ex_target_i != ex_pred_pc_i));
         end else begin
            mis_hit_o = ex_pred_taken_i;
         end
      end
   end

   assign redirect_pc_o = (ex_is_branch_i && ex_taken_i) ? ex_target_i
                                                         : ex_pc_i + 32'd4;

   always_comb begin
      cnt_nxt = ex_taken_i ? 2'b10 : 2'b01;
      if (e_hit) begin
         cnt_nxt = cnt_q[e_idx];
         if (ex_taken_i && cnt_q[e_idx] != 2'b11) begin
            cnt_nxt = cnt_q[e_idx] + 2'b01;
         end else if (!ex_taken_i && cnt_q[e_idx] != 2'b00) begin
            cnt_nxt = cnt_q[e_idx] - 2'b01;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            cnt_q[i] <= 2'b01;
         end
      end else if (upd) begin
         vld_q[e_idx] <= 1'b1;
         tag_q[e_idx] <= e_tag;
         cnt_q[e_idx] <= cnt_nxt;
         if (ex_taken_i) begin
            tgt_q[e_idx] <= ex_target_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         br_cnt_o   <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (upd && br_cnt_o != '1) begin
            br_cnt_o <= br_cnt_o + 32'd1;
         end
         if (ex_valid_i && mis_hit_o && miss_cnt_o != '1) begin
            miss_cnt_o <= miss_cnt_o + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Bench for branch_predictor_2bit: directed scenarios plus random traffic
// compared against a per-entry behavioural model.
module tb_branch_predictor_2bit;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [31:0] if_pc_i = '0;
   logic        pred_taken_o;
   logic [31:0] pred_pc_o;
   logic        ex_valid_i = 1'b0;
   logic [31:0] ex_pc_i = '0;
   logic        ex_is_branch_i = 1'b0;
   logic        ex_taken_i = 1'b0;
   logic [31:0] ex_target_i = '0;
   logic        ex_pred_taken_i = 1'b0;
   logic [31:0] ex_pred_pc_i = '0;
   logic        mis_hit_o;
   logic [31:0] redirect_pc_o;
   logic [31:0] br_cnt_o;
   logic [31:0] miss_cnt_o;

   int tests = 0;
   int fails = 0;

   branch_predictor_2bit dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .if_pc_i(if_pc_i),
      .pred_taken_o(pred_taken_o), .pred_pc_o(pred_pc_o),
      .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
      .ex_is_branch_i(ex_is_branch_i), .ex_taken_i(ex_taken_i),
      .ex_target_i(ex_target_i), .ex_pred_taken_i(ex_pred_taken_i),
      .ex_pred_pc_i(ex_pred_pc_i), .mis_hit_o(mis_hit_o),
      .redirect_pc_o(redirect_pc_o), .br_cnt_o(br_cnt_o),
      .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Model: each slot remembers the full PC that owns it and a strength 0..3.
   bit          m_vld [32];
   logic [31:0] m_pc  [32];
   logic [31:0] m_tgt [32];
   int          m_str [32];
   longint      m_br;
   longint      m_miss;

   function automatic int m_slot(input logic [31:0] pc);
      return int'((pc / 4) % 32);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      int s = m_slot(pc);
      return m_vld[s] && ((m_pc[s] / 128) == (pc / 128));
   endfunction

   function automatic bit m_ptaken(input logic [31:0] pc);
      return m_hit(pc) && (m_str[m_slot(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_ppc(input logic [31:0] pc);
      return m_ptaken(pc) ? m_tgt[m_slot(pc)] : pc + 32'd4;
   endfunction

   function automatic bit m_mis();
      if (!ex_valid_i) return 1'b0;
      if (!ex_is_branch_i) return ex_pred_taken_i;
      if (ex_taken_i != ex_pred_taken_i) return 1'b1;
      return ex_taken_i && (ex_target_i != ex_pred_pc_i);
   endfunction

   function automatic logic [31:0] m_redir();
      return (ex_is_branch_i && ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin
         m_vld[i] = 1'b0;
         m_pc[i]  = '0;
         m_tgt[i] = '0;
         m_str[i] = 1;
      end
      m_br = 0;
      m_miss = 0;
   endtask

   task automatic m_update();
      int s;
      if (!rst_ni || !ex_valid_i) return;
      if (m_mis() && m_miss < 64'hFFFF_FFFF) m_miss++;
      if (!ex_is_branch_i) return;
      s = m_slot(ex_pc_i);
      if (m_hit(ex_pc_i)) begin
         if (ex_taken_i) m_str[s] = (m_str[s] < 3) ? m_str[s] + 1 : 3;
         else m_str[s] = (m_str[s] > 0) ? m_str[s] - 1 : 0;
      end else begin
         m_str[s] = ex_taken_i ? 2 : 1;
      end
      m_vld[s] = 1'b1;
      m_pc[s] = ex_pc_i;
      if (ex_taken_i) m_tgt[s] = ex_target_i;
      if (m_br < 64'hFFFF_FFFF) m_br++;
   endtask

   task automatic drive_ex(input logic v, input logic [31:0] pc,
                           input logic br, input logic tk,
                           input logic [31:0] tgt, input logic ppt,
                           input logic [31:0] ppc);
      ex_valid_i = v;
      ex_pc_i = pc;
      ex_is_branch_i = br;
      ex_taken_i = tk;
      ex_target_i = tgt;
      ex_pred_taken_i = ppt;
      ex_pred_pc_i = ppc;
   endtask

   task automatic idle();
      drive_ex(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   // Apply the current inputs across one rising edge, then return at negedge.
   task automatic tick();
      @(posedge clk_i);
      m_update();
      @(negedge clk_i);
      idle();
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      m_reset();
      if_pc_i = 32'h100;
      drive_ex(1'b1, 32'h40, 1'b0, 1'b0, '0, 1'b1, '0);
      repeat (2) @(negedge clk_i);
      #1;
      tests++;
      if (pred_taken_o !== 1'b0 || pred_pc_o !== 32'h104) begin
         fails++;
         $display("FAIL reset_pred act=%0b/%h exp=0/00000104",
                  pred_taken_o, pred_pc_o);
      end
      tests++;
      if (mis_hit_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_mis act=%0b exp=0", mis_hit_o);
      end
      tests++;
      if (br_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
         fails++;
         $display("FAIL reset_cnt act=%0d/%0d exp=0/0", br_cnt_o, miss_cnt_o);
      end
      idle();
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_cold_miss();
      if_pc_i = 32'h100;
      drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104);
      #1;
      tests++;
      if (pred_taken_o !== 1'b0 || pred_pc_o !== 32'h104) begin
         fails++;
         $display("FAIL cold_lookup act=%0b/%h exp=0/00000104",
                  pred_taken_o, pred_pc_o);
      end
      tests++;
      if (mis_hit_o !== 1'b1 || redirect_pc_o !== 32'h200) begin
         fails++;
         $display("FAIL cold_mis act=%0b/%h exp=1/00000200",
                  mis_hit_o, redirect_pc_o);
      end
      tick();
      #1;
      tests++;
      if (pred_taken_o !== 1'b1 || pred_pc_o !== 32'h200) begin
         fails++;
         $display("FAIL cold_after act=%0b/%h exp=1/00000200",
                  pred_taken_o, pred_pc_o);
      end
      tests++;
      if (br_cnt_o !== 32'd1 || miss_cnt_o !== 32'd1) begin
         fails++;
         $display("FAIL cold_cnt act=%0d/%0d exp=1/1", br_cnt_o, miss_cnt_o);
      end
   endtask

   task automatic test_saturation();
      if_pc_i = 32'h100;
      repeat (3) begin
         drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);
         tick();
      end
      drive_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200);
      tick();
      #1;
      tests++;
      if (pred_taken_o !== 1'b1 || pred_pc_o !== 32'h200) begin
         fails++;
         $display("FAIL sat_hyst act=%0b/%h exp=1/00000200",
                  pred_taken_o, pred_pc_o);
      end
      drive_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200);
      tick();
      #1;
      tests++;
      if (pred_taken_o !== 1'b0 || pred_pc_o !== 32'h104) begin
         fails++;
         $display("FAIL sat_flip act=%0b/%h exp=0/00000104",
                  pred_taken_o, pred_pc_o);
      end
      tests++;
      if (br_cnt_o !== 32'd6 || miss_cnt_o !== 32'd3) begin
         fails++;
         $display("FAIL sat_cnt act=%0d/%0d exp=6/3", br_cnt_o, miss_cnt_o);
      end
   endtask

   task automatic test_alias();
      drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104);
      tick();
      drive_ex(1'b1, 32'h180, 1'b1, 1'b0, 32'h0, 1'b0, 32'h184);
      #1;
      tests++;
      if (mis_hit_o !== 1'b0) begin
         fails++;
         $display("FAIL alias_mis act=%0b exp=0", mis_hit_o);
      end
      tick();
      if_pc_i = 32'h100;
      #1;
      tests++;
      if (pred_taken_o !== 1'b0 || pred_pc_o !== 32'h104) begin
         fails++;
         $display("FAIL alias_evict act=%0b/%h exp=0/00000104",
                  pred_taken_o, pred_pc_o);
      end
      if_pc_i = 32'h180;
      #1;
      tests++;
      if (pred_taken_o !== 1'b0 || pred_pc_o !== 32'h184) begin
         fails++;
         $display("FAIL alias_new act=%0b/%h exp=0/00000184",
                  pred_taken_o, pred_pc_o);
      end
   endtask

   task automatic test_target_change();
      drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104);
      tick();
      drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200);
      #1;
      tests++;
      if (mis_hit_o !== 1'b1 || redirect_pc_o !== 32'h300) begin
         fails++;
         $display("FAIL tgt_mis act=%0b/%h exp=1/00000300",
                  mis_hit_o, redirect_pc_o);
      end
      tick();
      if_pc_i = 32'h100;
      #1;
      tests++;
      if (pred_taken_o !== 1'b1 || pred_pc_o !== 32'h300) begin
         fails++;
         $display("FAIL tgt_new act=%0b/%h exp=1/00000300",
                  pred_taken_o, pred_pc_o);
      end
   endtask

   task automatic test_non_branch();
      logic [31:0] br0;
      logic [31:0] miss0;
      br0 = 32'(m_br);
      miss0 = 32'(m_miss);
      drive_ex(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
      #1;
      tests++;
      if (mis_hit_o !== 1'b1 || redirect_pc_o !== 32'h44) begin
         fails++;
         $display("FAIL nb_mis act=%0b/%h exp=1/00000044",
                  mis_hit_o, redirect_pc_o);
      end
      tick();
      #1;
      tests++;
      if (br_cnt_o !== br0 || miss_cnt_o !== miss0 + 32'd1) begin
         fails++;
         $display("FAIL nb_cnt act=%0d/%0d exp=%0d/%0d",
                  br_cnt_o, miss_cnt_o, br0, miss0 + 32'd1);
      end
      if_pc_i = 32'h40;
      #1;
      tests++;
      if (pred_taken_o !== 1'b0 || pred_pc_o !== 32'h44) begin
         fails++;
         $display("FAIL nb_table act=%0b/%h exp=0/00000044",
                  pred_taken_o, pred_pc_o);
      end
   endtask

   task automatic test_same_cycle();
      if_pc_i = 32'h500;
      drive_ex(1'b1, 32'h500, 1'b1, 1'b1, 32'h600, 1'b0, 32'h504);
      #1;
      tests++;
      if (pred_taken_o !== 1'b0 || pred_pc_o !== 32'h504) begin
         fails++;
         $display("FAIL nofwd_before act=%0b/%h exp=0/00000504",
                  pred_taken_o, pred_pc_o);
      end
      tick();
      #1;
      tests++;
      if (pred_taken_o !== 1'b1 || pred_pc_o !== 32'h600) begin
         fails++;
         $display("FAIL nofwd_after act=%0b/%h exp=1/00000600",
                  pred_taken_o, pred_pc_o);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] pcs [3];
      pcs[0] = 32'h100;
      pcs[1] = 32'h500;
      pcs[2] = 32'h180;
      if_pc_i = 32'h100;
      drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h700, 1'b0, 32'h104);
      #2;
      rst_ni = 1'b0;
      #1;
      tests++;
      if (pred_taken_o !== 1'b0 || pred_pc_o !== 32'h104) begin
         fails++;
         $display("FAIL arst_pred act=%0b/%h exp=0/00000104",
                  pred_taken_o, pred_pc_o);
      end
      tests++;
      if (br_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0 || mis_hit_o !== 1'b0) begin
         fails++;
         $display("FAIL arst_cnt act=%0d/%0d/%0b exp=0/0/0",
                  br_cnt_o, miss_cnt_o, mis_hit_o);
      end
      m_reset();
      @(posedge clk_i);
      @(negedge clk_i);
      idle();
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if_pc_i = pcs[i];
         #1;
         tests++;
         if (pred_taken_o !== 1'b0 || pred_pc_o !== pcs[i] + 32'd4) begin
            fails++;
            $display("FAIL arst_miss pc=%h act=%0b/%h exp=0/%h",
                     pcs[i], pred_taken_o, pred_pc_o, pcs[i] + 32'd4);
         end
      end
      tests++;
      if (br_cnt_o !== 32'd0) begin
         fails++;
         $display("FAIL arst_noupd act=%0d exp=0", br_cnt_o);
      end
   endtask

   task automatic test_random();
      logic [31:0] pc;
      for (int n = 0; n < 400; n++) begin
         if_pc_i = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 2);
         pc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 2);
         if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
         ex_valid_i = ($urandom_range(0, 3) != 0);
         ex_pc_i = pc;
         ex_is_branch_i = ($urandom_range(0, 4) != 0);
         ex_taken_i = $urandom_range(0, 1);
         ex_target_i = {$urandom_range(0, 3), 2'b00} << 8;
         if ($urandom_range(0, 1) == 1) begin
            ex_pred_taken_i = m_ptaken(pc);
            ex_pred_pc_i = m_ppc(pc);
         end else begin
            ex_pred_taken_i = $urandom_range(0, 1);
            ex_pred_pc_i = {$urandom_range(0, 3), 2'b00} << 8;
         end
         #1;
         tests++;
         if (pred_taken_o !== m_ptaken(if_pc_i) ||
             pred_pc_o !== m_ppc(if_pc_i)) begin
            fails++;
            $display("FAIL rnd_pred n=%0d pc=%h act=%0b/%h exp=%0b/%h", n,
                     if_pc_i, pred_taken_o, pred_pc_o,
                     m_ptaken(if_pc_i), m_ppc(if_pc_i));
         end
         tests++;
         if (mis_hit_o !== m_mis() ||
             (ex_valid_i && redirect_pc_o !== m_redir())) begin
            fails++;
            $display("FAIL rnd_mis n=%0d act=%0b/%h exp=%0b/%h", n,
                     mis_hit_o, redirect_pc_o, m_mis(), m_redir());
         end
         tick();
         #1;
         tests++;
         if (br_cnt_o !== 32'(m_br) || miss_cnt_o !== 32'(m_miss)) begin
            fails++;
            $display("FAIL rnd_cnt n=%0d act=%0d/%0d exp=%0d/%0d", n,
                     br_cnt_o, miss_cnt_o, m_br, m_miss);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_saturation();
      test_alias();
      test_target_change();
      test_non_branch();
      test_same_cycle();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/branch_predictor_2bit.md
BRANCH_PREDICTOR_2BIT -- requirements
Module: branch_predictor_2bit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): ENTRIES, 32, number of table entries; IDX_W, 5, index width, equal to log2(ENTRIES).
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- if_pc_i  in  32  fetch-stage PC to look up.
- pred_taken_o  out  1  fetch prediction: taken.
- pred_pc_o  out  32  predicted next PC.
- ex_valid_i  in  1  EX stage holds a real (non-bubble) instruction.
- ex_pc_i  in  32  PC of the EX instruction.
- ex_is_branch_i  in  1  EX instruction is a conditional branch or jal.
- ex_taken_i  in  1  resolved outcome.
- ex_target_i  in  32  resolved taken target.
- ex_pred_taken_i  in  1  prediction carried down the pipe for this instruction.
- ex_pred_pc_i  in  32  predicted PC carried down the pipe.
- mis_hit_o  out  1  misprediction flag, consumed by the pipeline-register control.
- redirect_pc_o  out  32  correct next PC when mis_hit_o=1.
- br_cnt_o  out  32  count of resolved branches.
- miss_cnt_o  out  32  count of mispredictions.

Function
REQ-003 The block SHALL hold ENTRIES entries, each with: valid (1 bit), tag = pc[31:IDX_W+2], target (32 bits), and a 2-bit counter.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-004 Both lookup and update SHALL index the table with pc[IDX_W+1:2].
REQ-005 Lookup SHALL be combinational from if_pc_i.
- hit = valid && tag match.
- pred_taken_o = hit && counter[1].
- pred_pc_o = pred_taken_o ? target : if_pc_i+4, with the addition modulo 2^32 (0xFFFFFFFC+4 gives 0).
REQ-006 mis_hit_o SHALL be combinational and equal 1 when ex_valid_i=1 and any of these holds:
- ex_is_branch_i=1 and ex_taken_i != ex_pred_taken_i;
- ex_is_branch_i=1, ex_taken_i=1, and ex_target_i != ex_pred_pc_i;
- ex_is_branch_i=0 and ex_pred_taken_i=1.
Otherwise mis_hit_o SHALL be 0.
REQ-007 redirect_pc_o SHALL equal:
- ex_target_i when ex_is_branch_i=1 and ex_taken_i=1;
- ex_pc_i+4 otherwise.
REQ-008 The table SHALL update only on a rising clk_i edge where ex_valid_i=1 and ex_is_branch_i=1.
- Exactly one entry, at the ex_pc_i index, changes per cycle.
REQ-009 Update on a hit (valid, tag match):
- Counter saturating increment if taken (11 stays 11), saturating decrement if not taken (00 stays 00).
- Target written with ex_target_i only if taken.
REQ-010 Update on a miss (invalid or tag mismatch) SHALL allocate the entry:
- valid=1, tag from ex_pc_i;
- counter = 10 if taken, 01 if not;
- target = ex_target_i if taken, otherwise unchanged.
REQ-011 A non-branch instruction with ex_pred_taken_i=1 SHALL set mis_hit_o but SHALL NOT modify the table.
REQ-012 Lookup and update SHALL NOT be forwarded: when they address the same index in the same cycle, the lookup returns pre-update contents and the new contents are visible the next cycle.
REQ-013 Update latency SHALL be 1 cycle.
REQ-014 Prediction and mis_hit_o SHALL have 0-cycle latency.
REQ-015 The performance counters SHALL increment on the update edge as follows:
- br_cnt_o by 1 per qualifying update (REQ-008);
- miss_cnt_o by 1 per cycle with ex_valid_i=1 and mis_hit_o=1;
- both saturate at 0xFFFFFFFF.
REQ-016 With ex_valid_i=0, mis_hit_o SHALL be 0 and no state or counter SHALL change.

Reset
REQ-017 rst_ni=0 SHALL asynchronously clear all valid bits, set all counters to 01, clear all targets and tags to 0, and clear br_cnt_o and miss_cnt_o to 0.
REQ-018 While rst_ni=0:
- pred_taken_o SHALL be 0 and pred_pc_o = if_pc_i+4;
- mis_hit_o SHALL be 0;
- no update SHALL occur.
REQ-019 An assertion of reset in the same cycle as an update SHALL win, leaving the entry in its reset state.
REQ-020 Deassertion of rst_ni SHALL be honoured on the following rising edge; the first update can occur on that edge.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Cold-miss branch: after reset, if_pc_i=0x100 -> pred_taken_o=0, pred_pc_o=0x104. Resolve ex_pc_i=0x100, taken, target 0x200, pred_taken=0 -> mis_hit_o=1, redirect_pc_o=0x200. Next cycle, lookup 0x100 -> pred_taken_o=1, pred_pc_o=0x200; br_cnt_o=1, miss_cnt_o=1.
- Saturation and hysteresis: resolve 0x100 taken 3 times -> counter 11. One not-taken -> still predicts taken (10). Second not-taken -> predicts not-taken (01).
- Alias eviction: 0x100 allocated taken; resolve 0x180 (same index, different tag) not-taken -> lookup 0x100 misses (pred_pc_o=0x104); lookup 0x180 -> pred_taken_o=0.
- Target change: 0x100 taken to 0x200, then resolve taken to 0x300 with ex_pred_pc_i=0x200 -> mis_hit_o=1, redirect 0x300; subsequent lookup -> pred_pc_o=0x300.
- Non-branch false-taken: ex_is_branch_i=0, ex_pred_taken_i=1, ex_pc_i=0x40 -> mis_hit_o=1, redirect_pc_o=0x44, table unchanged, br_cnt_o unchanged, miss_cnt_o+1.
- Async reset mid-run: pull rst_ni low between edges -> pred_taken_o=0 and counters read 0 immediately, without waiting for a clock edge; all entries miss after release.
